ild_ddnn_sequencer: RTL and testbench

ILD_DDNN_SEQUENCER -- requirements
Module: ild_ddnn_sequencer

---
 rtl/ild_ddnn_sequencer_pkg.sv | 22 ++
 rtl/ild_ddnn_sequencer_xpt_counter.sv | 47 ++++
 rtl/ild_ddnn_sequencer.sv | 166 ++++++++++++++++
 tb/tb_ild_ddnn_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ild_ddnn_sequencer_pkg.sv
// Shared definitions for the LD dd,nn sequencer: FSM state encoding,
// register-pair codes and the execution-phase counter width.
package ild_ddnn_sequencer_pkg;

   localparam int unsigned XptWidth = 5;

   typedef enum logic [2:0] {
      StIdle,
      StFetchLo,
      StWriteLo,
      StFetchHi,
      StWriteHi
   } state_e;

   typedef enum logic [1:0] {
      PairBc = 2'd0,
      PairDe = 2'd1,
      PairHl = 2'd2,
      PairSp = 2'd3
   } pair_e;

endpackage

// File: rtl/ild_ddnn_sequencer_xpt_counter.sv
// Execution-phase counter fed back to the instruction decoder.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   load_one    - force the count to 1 (start of a sequence)
//   incr        - increment, saturating at all-ones
//   clear       - force the count to 0 (highest priority after reset)
//   xpt/not_xpt - current count and its bitwise inverse
module xpt_counter
   import ild_ddnn_sequencer_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                load_one,
   input  logic                incr,
   input  logic                clear,
   output logic [XptWidth-1:0] xpt,
   output logic [XptWidth-1:0] not_xpt
);

   localparam logic [XptWidth-1:0] XptMax = '1;
   localparam logic [XptWidth-1:0] XptOne = XptWidth'(1);

   logic [XptWidth-1:0] xpt_q, xpt_d;

   always_comb begin
      xpt_d = xpt_q;
      if (clear) begin
         xpt_d = '0;
      end else if (load_one) begin
         xpt_d = XptOne;
      end else if (incr && (xpt_q != XptMax)) begin
         xpt_d = xpt_q + XptOne;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         xpt_q <= '0;
      end else begin
         xpt_q <= xpt_d;
      end
   end

   assign xpt     = xpt_q;
   assign not_xpt = ~xpt_q;

endmodule

// File: rtl/ild_ddnn_sequencer.sv
// LD dd,nn sequencer: on a decoder start pulse, fetches the low then high
// immediate byte from memory at PC and writes them to the selected register
// pair, pulsing PC_Inc after each byte. A fetch that waits TIMEOUT_CYCLES
// without Mem_Ack aborts the sequence with a one-cycle Error pulse.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   P2_Set_ILDddnn_*_0         - start pulses (priority BC > DE > HL > SP)
//   PR_Reset_XPT               - clear XPT while idle
//   PC                         - program counter, used as fetch address
//   Mem_Ack, Mem_Data          - read data valid / read data
//   XPT, notXPT                - execution-phase counter and its inverse
//   Mem_Req, Mem_Addr          - read request / address
//   PC_Inc                     - PC increment pulse after each byte write
//   Reg_Write_Sel/Low/High/Data- register-pair write port
//   Busy, Done, Error          - status
module ild_ddnn_sequencer
   import ild_ddnn_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                P2_Set_ILDddnn_BC_0,
   input  logic                P2_Set_ILDddnn_DE_0,
   input  logic                P2_Set_ILDddnn_HL_0,
   input  logic                P2_Set_ILDddnn_SP_0,
   input  logic                PR_Reset_XPT,
   input  logic [15:0]         PC,
   input  logic                Mem_Ack,
   input  logic [7:0]          Mem_Data,
   output logic [XptWidth-1:0] XPT,
   output logic [XptWidth-1:0] notXPT,
   output logic                Mem_Req,
   output logic [15:0]         Mem_Addr,
   output logic                PC_Inc,
   output logic [1:0]          Reg_Write_Sel,
   output logic                Reg_Write_Low,
   output logic                Reg_Write_High,
   output logic [7:0]          Reg_Write_Data,
   output logic                Busy,
   output logic                Done,
   output logic                Error
);

   localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYCLES);

   state_e     state_q, state_d;
   pair_e      pair_q, pair_d;
   logic [7:0] data_q, data_d;
   logic [7:0] wait_q, wait_d;
   logic       error_q, error_d;
   logic       xpt_load, xpt_incr, xpt_clear;
   logic       start_any;

   assign start_any = P2_Set_ILDddnn_BC_0 | P2_Set_ILDddnn_DE_0 |
                      P2_Set_ILDddnn_HL_0 | P2_Set_ILDddnn_SP_0;

   always_comb begin
      state_d        = state_q;
      pair_d         = pair_q;
      data_d         = data_q;
      wait_d         = wait_q;
      error_d        = 1'b0;
      xpt_load       = 1'b0;
      xpt_incr       = 1'b0;
      xpt_clear      = 1'b0;
      Mem_Req        = 1'b0;
      Mem_Addr       = '0;
      PC_Inc         = 1'b0;
      Reg_Write_Low  = 1'b0;
      Reg_Write_High = 1'b0;
      Reg_Write_Data = '0;
      Done           = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_any) begin
               if (P2_Set_ILDddnn_BC_0) begin
                  pair_d = PairBc;
               end else if (P2_Set_ILDddnn_DE_0) begin
                  pair_d = PairDe;
               end else if (P2_Set_ILDddnn_HL_0) begin
                  pair_d = PairHl;
               end else begin
                  pair_d = PairSp;
               end
               xpt_load = 1'b1;
               state_d  = StFetchLo;
            end else if (PR_Reset_XPT) begin
               xpt_clear = 1'b1;
            end
         end

         StFetchLo, StFetchHi: begin
            Mem_Req  = 1'b1;
            Mem_Addr = PC;
            if (Mem_Ack) begin
               data_d   = Mem_Data;
               wait_d   = '0;
               xpt_incr = 1'b1;
               state_d  = (state_q == StFetchLo) ? StWriteLo : StWriteHi;
            end else if ((wait_q + 8'd1) == TimeoutVal) begin
               // Abort: no write, XPT back to 0, Error pulses in the idle cycle.
               wait_d    = '0;
               error_d   = 1'b1;
               xpt_clear = 1'b1;
               state_d   = StIdle;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end

         StWriteLo: begin
            Reg_Write_Low  = 1'b1;
            PC_Inc         = 1'b1;
            Reg_Write_Data = data_q;
            xpt_incr       = 1'b1;
            state_d        = StFetchHi;
         end

         StWriteHi: begin
            Reg_Write_High = 1'b1;
            PC_Inc         = 1'b1;
            Reg_Write_Data = data_q;
            Done           = 1'b1;
            xpt_clear      = 1'b1;
            state_d        = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         pair_q  <= PairBc;
         data_q  <= '0;
         wait_q  <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pair_q  <= pair_d;
         data_q  <= data_d;
         wait_q  <= wait_d;
         error_q <= error_d;
      end
   end

   xpt_counter u_xpt_counter (
      .clk      (clk),
      .reset    (reset),
      .load_one (xpt_load),
      .incr     (xpt_incr),
      .clear    (xpt_clear),
      .xpt      (XPT),
      .not_xpt  (notXPT)
   );

   assign Reg_Write_Sel = pair_q;
   assign Busy          = (state_q != StIdle);
   assign Error         = error_q;

endmodule

// File: tb/tb_ild_ddnn_sequencer.sv
// Self-checking bench for ild_ddnn_sequencer. Expected behaviour comes from
// a cycle schedule computed arithmetically from the start edge, stall counts
// and the timeout limit.
module tb_ild_ddnn_sequencer;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        P2_Set_ILDddnn_BC_0, P2_Set_ILDddnn_DE_0;
   logic        P2_Set_ILDddnn_HL_0, P2_Set_ILDddnn_SP_0;
   logic        PR_Reset_XPT;
   logic [15:0] PC;
   logic        Mem_Ack;
   logic [7:0]  Mem_Data;
   logic [4:0]  XPT, notXPT;
   logic        Mem_Req;
   logic [15:0] Mem_Addr;
   logic        PC_Inc;
   logic [1:0]  Reg_Write_Sel;
   logic        Reg_Write_Low, Reg_Write_High;
   logic [7:0]  Reg_Write_Data;
   logic        Busy, Done, Error;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic pend_error = 1'b0;

   localparam logic [40:0] ResetVec = {5'd0, 5'h1f, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0,
                                       8'h0, 1'b0, 1'b0, 1'b0};

   always #5 clk = ~clk;

   ild_ddnn_sequencer #(
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .P2_Set_ILDddnn_BC_0 (P2_Set_ILDddnn_BC_0),
      .P2_Set_ILDddnn_DE_0 (P2_Set_ILDddnn_DE_0),
      .P2_Set_ILDddnn_HL_0 (P2_Set_ILDddnn_HL_0),
      .P2_Set_ILDddnn_SP_0 (P2_Set_ILDddnn_SP_0),
      .PR_Reset_XPT        (PR_Reset_XPT),
      .PC                  (PC),
      .Mem_Ack             (Mem_Ack),
      .Mem_Data            (Mem_Data),
      .XPT                 (XPT),
      .notXPT              (notXPT),
      .Mem_Req             (Mem_Req),
      .Mem_Addr            (Mem_Addr),
      .PC_Inc              (PC_Inc),
      .Reg_Write_Sel       (Reg_Write_Sel),
      .Reg_Write_Low       (Reg_Write_Low),
      .Reg_Write_High      (Reg_Write_High),
      .Reg_Write_Data      (Reg_Write_Data),
      .Busy                (Busy),
      .Done                (Done),
      .Error               (Error)
   );

   function automatic logic [40:0] observed();
      return {XPT, notXPT, Mem_Req, Mem_Addr, PC_Inc, Reg_Write_Low, Reg_Write_High,
              Reg_Write_Data, Busy, Done, Error};
   endfunction

   // Phase in cycle k after the start edge: 0 idle, 1 fetch lo, 2 write lo,
   // 3 fetch hi, 4 write hi. A fetch stalled for TO cycles aborts to idle.
   function automatic int phase_of(int k, int dlo, int dhi);
      if (k < 1) return 0;
      if (dlo >= TO) return (k <= TO) ? 1 : 0;
      if (k <= dlo + 1) return 1;
      if (k == dlo + 2) return 2;
      if (dhi >= TO) return (k <= dlo + 2 + TO) ? 3 : 0;
      if (k <= dlo + dhi + 3) return 3;
      if (k == dlo + dhi + 4) return 4;
      return 0;
   endfunction

   task automatic set_starts(input logic [3:0] s);
      {P2_Set_ILDddnn_BC_0, P2_Set_ILDddnn_DE_0,
       P2_Set_ILDddnn_HL_0, P2_Set_ILDddnn_SP_0} = s;
   endtask

   // One LD dd,nn transaction; starts = {bc,de,hl,sp}. Ends in the cycle
   // after the last busy cycle, leaving pend_error for the next check.
   task automatic run_seq(input string name, input logic [3:0] starts, input int dlo,
                          input int dhi, input logic [7:0] lo_b, input logic [7:0] hi_b,
                          input bit stray);
      int          k_last;
      logic [1:0]  e_sel;
      logic [40:0] e_vec;
      logic [40:0] o_vec;
      e_sel  = starts[3] ? 2'd0 : starts[2] ? 2'd1 : starts[1] ? 2'd2 : 2'd3;
      k_last = (dlo >= TO) ? TO : (dhi >= TO) ? (dlo + 2 + TO) : (dlo + dhi + 4);

      PC           = 16'($urandom);
      Mem_Ack      = 1'($urandom);
      Mem_Data     = 8'($urandom);
      PR_Reset_XPT = 1'b0;
      set_starts(starts);
      @(negedge clk);
      n_tests++;
      e_vec = {5'd0, 5'h1f, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, pend_error};
      o_vec = observed();
      if (o_vec !== e_vec)
         begin n_fail++;
         $display("FAIL %s idle-before-start: got %h expected %h", name, o_vec, e_vec); end
      @(posedge clk); #1;
      set_starts(4'b0000);

      for (int k = 1; k <= k_last; k++) begin
         int ph;
         ph       = phase_of(k, dlo, dhi);
         PC       = 16'($urandom);
         Mem_Data = 8'($urandom);
         if (ph == 1) begin
            Mem_Ack = (k == dlo + 1);
            if (Mem_Ack) Mem_Data = lo_b;
         end else if (ph == 3) begin
            Mem_Ack = (k == dlo + dhi + 3);
            if (Mem_Ack) Mem_Data = hi_b;
         end else begin
            Mem_Ack = 1'($urandom);
         end
         P2_Set_ILDddnn_BC_0 = stray ? 1'($urandom) : 1'b0;
         PR_Reset_XPT        = stray ? 1'($urandom) : 1'b0;
         @(negedge clk);
         e_vec = {5'(ph), ~5'(ph), (ph == 1 || ph == 3),
                  (ph == 1 || ph == 3) ? PC : 16'h0,
                  (ph == 2 || ph == 4), (ph == 2), (ph == 4),
                  (ph == 2) ? lo_b : (ph == 4) ? hi_b : 8'h0,
                  (ph != 0), (ph == 4), 1'b0};
         o_vec = observed();
         n_tests++;
         if (o_vec !== e_vec)
            begin n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, k, o_vec, e_vec); end
         n_tests++;
         if (Reg_Write_Sel !== e_sel)
            begin n_fail++;
            $display("FAIL %s sel cycle %0d: got %0d expected %0d", name, k, Reg_Write_Sel,
                     e_sel); end
         @(posedge clk); #1;
      end
      set_starts(4'b0000);
      PR_Reset_XPT = 1'b0;
      pend_error   = (dlo >= TO) || (dhi >= TO);
   endtask

   // Idle cycles with random PR_Reset_XPT / stray Mem_Ack: nothing may move.
   task automatic idle_check(input string name, input int n);
      logic [40:0] e_vec;
      logic [40:0] o_vec;
      for (int i = 0; i < n; i++) begin
         set_starts(4'b0000);
         PR_Reset_XPT = 1'($urandom);
         Mem_Ack      = 1'($urandom);
         Mem_Data     = 8'($urandom);
         PC           = 16'($urandom);
         @(negedge clk);
         e_vec = {5'd0, 5'h1f, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, pend_error};
         o_vec = observed();
         n_tests++;
         if (o_vec !== e_vec)
            begin n_fail++;
            $display("FAIL %s idle %0d: got %h expected %h", name, i, o_vec, e_vec); end
         pend_error = 1'b0;
         @(posedge clk); #1;
      end
      PR_Reset_XPT = 1'b0;
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      set_starts(4'b1111);
      PR_Reset_XPT = 1'b0;
      Mem_Ack      = 1'b1;
      Mem_Data     = 8'h5a;
      PC           = 16'h1234;
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++;
      if (observed() !== ResetVec)
         begin n_fail++;
         $display("FAIL reset_outputs: got %h expected %h", observed(), ResetVec); end
      n_tests++;
      if (Reg_Write_Sel !== 2'd0)
         begin n_fail++;
         $display("FAIL reset_sel: got %0d expected 0", Reg_Write_Sel); end
      @(posedge clk); #1;
      reset = 1'b0;
      set_starts(4'b0000);
      pend_error = 1'b0;
      idle_check("start_with_reset", 3);
   endtask

   task automatic test_basic_de();
      run_seq("basic_de", 4'b0100, 0, 0, 8'h34, 8'h12, 1'b0);
      idle_check("basic_de_tail", 1);
   endtask

   task automatic test_stall_sp();
      run_seq("stall_sp", 4'b0001, 3, 0, 8'hc3, 8'h3c, 1'b0);
      idle_check("stall_sp_tail", 1);
   endtask

   task automatic test_priority();
      run_seq("prio_hl_sp", 4'b0011, 0, 1, 8'h77, 8'h88, 1'b1);
      idle_check("prio_tail", 1);
      run_seq("prio_all", 4'b1111, 1, 0, 8'h01, 8'h02, 1'b0);
      idle_check("prio_all_tail", 1);
   endtask

   task automatic test_timeout();
      run_seq("timeout_lo", 4'b1000, TO, 0, 8'h00, 8'h00, 1'b0);
      idle_check("timeout_lo_tail", 2);
      run_seq("timeout_hi", 4'b0010, 0, TO, 8'h9e, 8'h00, 1'b1);
      idle_check("timeout_hi_tail", 2);
   endtask

   task automatic test_reset_mid();
      set_starts(4'b1000);
      Mem_Ack  = 1'b1;
      Mem_Data = 8'ha5;
      @(posedge clk); #1;
      set_starts(4'b0000);
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++;
      if ({Reg_Write_Low, Reg_Write_Data} !== {1'b1, 8'ha5})
         begin n_fail++;
         $display("FAIL reset_mid_write_lo: got %b/%h expected 1/a5", Reg_Write_Low,
                  Reg_Write_Data); end
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++;
      if (observed() !== ResetVec)
         begin n_fail++;
         $display("FAIL reset_mid_outputs: got %h expected %h", observed(), ResetVec); end
      n_tests++;
      if (Reg_Write_Sel !== 2'd0)
         begin n_fail++;
         $display("FAIL reset_mid_sel: got %0d expected 0", Reg_Write_Sel); end
      reset   = 1'b0;
      Mem_Ack = 1'b0;
      @(posedge clk); #1;
      pend_error = 1'b0;
      idle_check("reset_mid_after", 4);
   endtask

   task automatic test_pr_reset();
      PR_Reset_XPT = 1'b1;
      @(posedge clk); #1;
      PR_Reset_XPT = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({XPT, notXPT} !== {5'd0, 5'h1f})
         begin n_fail++;
         $display("FAIL pr_reset_idle: got %h/%h expected 00/1f", XPT, notXPT); end
      @(posedge clk); #1;
      run_seq("pr_reset_mid", 4'b0100, 2, 2, 8'h5b, 8'hb5, 1'b1);
      idle_check("pr_reset_tail", 1);
   endtask

   task automatic test_back_to_back();
      run_seq("b2b_first", 4'b0010, 0, 0, 8'hde, 8'had, 1'b0);
      run_seq("b2b_second", 4'b1000, 0, 0, 8'hbe, 8'hef, 1'b0);
      run_seq("b2b_after_abort", 4'b0001, TO + 1, 0, 8'h00, 8'h00, 1'b0);
      run_seq("b2b_third", 4'b0100, 1, 2, 8'h11, 8'h22, 1'b0);
      idle_check("b2b_tail", 1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         run_seq("random", 4'($urandom_range(1, 15)), int'($urandom_range(0, TO + 1)),
                 int'($urandom_range(0, TO + 1)), 8'($urandom), 8'($urandom), 1'b1);
         if ($urandom_range(0, 1) == 1) idle_check("random_gap", int'($urandom_range(1, 3)));
      end
      idle_check("random_tail", 2);
   endtask

   initial begin
      test_reset();
      test_basic_de();
      test_stall_sp();
      test_priority();
      test_timeout();
      test_reset_mid();
      test_pr_reset();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
